// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl
//   Takes decoded SPI frames from spi_slave, keeps one brightness register
//   (0..MAX_PCT percent) per LED, drives the LED pins with PWM and builds
//   the readback frame for read commands.
//
//   Optional build macro: LED_ERR_STATUS_EN
//     Adds an 8-bit saturating count of cmd_err pulses. Address 8'hFF then
//     becomes a status address: READ returns the count, WRITE clears it.
//
// Ports
//   sysclk      in   system clock (125 MHz)
//   rst_n       in   asynchronous active-low reset, synchronous release
//   frame_valid in   one-cycle strobe, cmd/addr/payload valid
//   cmd         in   command byte
//   addr        in   LED index
//   payload     in   brightness in percent
//   cs          in   SPI chip select (active low), ends the readback window
//   tx_frame    out  response frame {cmd, addr, brightness}
//   tx_enb      out  response valid
//   led         out  PWM outputs, active high
//   cmd_err     out  one-cycle pulse on a rejected frame
module led_pwm_ctrl #(
    parameter int         NUM_LEDS  = 4,
    parameter int         PWM_DIV   = 125,
    parameter logic [7:0] CMD_WRITE = 8'h01,
    parameter logic [7:0] CMD_READ  = 8'h02,
    parameter int         MAX_PCT   = 100
) (
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic                frame_valid,
    input  logic [7:0]          cmd,
    input  logic [7:0]          addr,
    input  logic [7:0]          payload,
    input  logic                cs,
    output logic [23:0]         tx_frame,
    output logic                tx_enb,
    output logic [NUM_LEDS-1:0] led,
    output logic                cmd_err
);

    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [7:0] CMD_NOP = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WRITE,
        READ_LOAD,
        TX_HOLD
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  cmd_q, addr_q, payload_q;
    logic [6:0]  brightness [NUM_LEDS];
    logic [6:0]  shadow     [NUM_LEDS];
    logic [PW-1:0] presc;
    logic [6:0]  step_cnt;
    logic        tick, period_end;
    logic        err_nxt, wr_en, rd_load, tx_clr;
    logic        addr_ok, cmd_ok;
    logic [7:0]  rd_val;

    // Payloads above full scale saturate silently; compare on all 8 bits.
    function automatic logic [6:0] clamp_pct(input logic [7:0] p);
        if (p > 8'(MAX_PCT))
            return 7'(MAX_PCT);
        return p[6:0];
    endfunction

`ifdef LED_ERR_STATUS_EN
    logic [7:0] err_cnt;
    assign addr_ok = (int'(addr_q) < NUM_LEDS) || (addr_q == 8'hFF);
`else
    assign addr_ok = (int'(addr_q) < NUM_LEDS);
`endif
    assign cmd_ok = (cmd_q == CMD_WRITE) || (cmd_q == CMD_READ) || (cmd_q == CMD_NOP);

    // Readback value for the latched address.
    always_comb begin
        rd_val = 8'h00;
        for (int i = 0; i < NUM_LEDS; i++)
            if (addr_q == 8'(i))
                rd_val = {1'b0, brightness[i]};
`ifdef LED_ERR_STATUS_EN
        if (addr_q == 8'hFF)
            rd_val = err_cnt;
`endif
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        wr_en     = 1'b0;
        rd_load   = 1'b0;
        tx_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_valid)
                    state_nxt = DECODE;
            end
            DECODE: begin
                if (frame_valid)
                    err_nxt = 1'b1;
                if (!addr_ok || !cmd_ok) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (cmd_q == CMD_WRITE) begin
                    state_nxt = WRITE;
                end else if (cmd_q == CMD_READ) begin
                    state_nxt = READ_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                wr_en     = 1'b1;
                err_nxt   = frame_valid;
                state_nxt = IDLE;
            end
            READ_LOAD: begin
                rd_load   = 1'b1;
                err_nxt   = frame_valid;
                state_nxt = TX_HOLD;
            end
            TX_HOLD: begin
                // Master is still clocking out the readback: frames are
                // dropped here without raising an error.
                if (cs) begin
                    tx_clr    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd_err  <= 1'b0;
            tx_enb   <= 1'b0;
            tx_frame <= 24'h0;
        end else begin
            state   <= state_nxt;
            cmd_err <= err_nxt;
            if (rd_load) begin
                tx_enb   <= 1'b1;
                tx_frame <= {CMD_READ, addr_q, rd_val};
            end else if (tx_clr) begin
                tx_enb   <= 1'b0;
                tx_frame <= 24'h0;
            end
        end
    end

    // Frame capture; only meaningful once the FSM leaves IDLE.
    always_ff @(posedge sysclk) begin
        if (state == IDLE && frame_valid) begin
            cmd_q     <= cmd;
            addr_q    <= addr;
            payload_q <= payload;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++)
                brightness[i] <= 7'd0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++)
                if (wr_en && addr_q == 8'(i))
                    brightness[i] <= clamp_pct(payload_q);
        end
    end

`ifdef LED_ERR_STATUS_EN
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= 8'h00;
        else if (wr_en && addr_q == 8'hFF)
            err_cnt <= 8'h00;
        else if (err_nxt && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'h01;
    end
`endif

    // PWM timebase: prescaler tick every PWM_DIV cycles, MAX_PCT steps per period.
    assign tick       = (presc == PW'(PWM_DIV - 1));
    assign period_end = tick && (step_cnt == 7'(MAX_PCT - 1));

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            step_cnt <= 7'd0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                step_cnt <= period_end ? 7'd0 : step_cnt + 7'd1;
        end
    end

    // Shadow duties only change at the period boundary, so a write never
    // truncates or stretches the pulse already in progress.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++)
                shadow[i] <= 7'd0;
            led <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (period_end)
                    shadow[i] <= brightness[i];
                led[i] <= (step_cnt < shadow[i]);
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
module tb_led_pwm_ctrl;

    localparam int NL      = 4;
    localparam int DIV     = 2;
    localparam int PERIOD  = 100 * DIV;
    localparam logic [7:0] WR = 8'h01;
    localparam logic [7:0] RD = 8'h02;

    logic          sysclk = 1'b0;
    logic          rst_n;
    logic          frame_valid;
    logic [7:0]    cmd, addr, payload;
    logic          cs;
    logic [23:0]   tx_frame;
    logic          tx_enb;
    logic [NL-1:0] led;
    logic          cmd_err;

    int n_chk = 0;
    int n_err = 0;
    int err_seen = 0;
    int err_exp = 0;
    logic tx_enb_d = 1'b0;
    logic [23:0] exp_q[$];
    int hi_cnt [NL];

    led_pwm_ctrl #(.NUM_LEDS(NL), .PWM_DIV(DIV)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .frame_valid(frame_valid),
        .cmd(cmd), .addr(addr), .payload(payload), .cs(cs),
        .tx_frame(tx_frame), .tx_enb(tx_enb), .led(led), .cmd_err(cmd_err)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: pop an expected frame each time a response appears.
    always @(negedge sysclk) begin
        if (tx_enb && !tx_enb_d) begin
            if (exp_q.size() == 0)
                chk("tx_unexpected", 1, 0);
            else
                chk("tx_frame", tx_frame, exp_q.pop_front());
        end
        tx_enb_d = tx_enb;
        if (cmd_err)
            err_seen++;
    end

    task automatic pulse_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
        @(negedge sysclk);
        cmd = c; addr = a; payload = p; frame_valid = 1'b1;
        @(negedge sysclk);
        frame_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
        pulse_frame(c, a, p);
        repeat (4) @(negedge sysclk);
    endtask

    task automatic wait_tx();
        int n = 0;
        while (!tx_enb && n < 10) begin
            @(negedge sysclk);
            n++;
        end
        if (!tx_enb) begin
            chk("rd_timeout", 0, 1);
            if (exp_q.size() != 0)
                void'(exp_q.pop_back());
        end
    endtask

    task automatic read_led(input logic [7:0] a, input logic [7:0] v, input bit inject);
        cs = 1'b0;
        exp_q.push_back({RD, a, v});
        pulse_frame(RD, a, 8'h00);
        wait_tx();
        if (inject)
            pulse_frame(WR, 8'd1, 8'd0);
        repeat (2) @(negedge sysclk);
        chk("rd_hold", tx_enb, 1);
        cs = 1'b1;
        repeat (2) @(negedge sysclk);
        chk("rd_enb_clr", tx_enb, 0);
        chk("rd_frame_clr", tx_frame, 0);
    endtask

    task automatic measure();
        for (int i = 0; i < NL; i++) hi_cnt[i] = 0;
        repeat (PERIOD) begin
            @(negedge sysclk);
            for (int i = 0; i < NL; i++) hi_cnt[i] += int'(led[i]);
        end
    endtask

    task automatic run_len(input int idx, input logic lvl, output int n);
        n = 0;
        while (led[idx] == lvl && n < 1000) begin
            n++;
            @(negedge sysclk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_hi, n_lo, n_hi2, n;
        rst_n = 1'b0; frame_valid = 1'b0; cmd = 0; addr = 0; payload = 0; cs = 1'b1;
        repeat (3) @(negedge sysclk);
        chk("rst_led", led, 0);
        chk("rst_tx_enb", tx_enb, 0);
        chk("rst_tx_frame", tx_frame, 0);
        chk("rst_cmd_err", cmd_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);

        // Write latency: visible exactly three edges after frame_valid.
        pulse_frame(WR, 8'd1, 8'd50);
        @(negedge sysclk);
        chk("wr_lat_early", dut.brightness[1], 0);
        @(negedge sysclk);
        chk("wr_lat", dut.brightness[1], 50);
        repeat (3) @(negedge sysclk);

        send(WR, 8'd0, 8'd200);
        repeat (2 * PERIOD) @(negedge sysclk);
        measure();
        chk("duty_led0_full", hi_cnt[0], PERIOD);
        chk("duty_led1_half", hi_cnt[1], 50 * DIV);
        chk("duty_led2_zero", hi_cnt[2], 0);
        chk("clamp_no_err", err_seen, 0);

        send(WR, 8'd2, 8'd30);
        read_led(8'd2, 8'd30, 1'b1);
        chk("txhold_drop_no_err", err_seen, 0);

        send(WR, 8'd7, 8'd10);
        err_exp++;
        chk("err_bad_addr", err_seen, err_exp);
        send(8'h55, 8'd0, 8'd10);
        err_exp++;
        chk("err_bad_cmd", err_seen, err_exp);
        send(8'h00, 8'd3, 8'd77);
        chk("nop_silent", err_seen, err_exp);

        // Back-to-back frames: the second lands in DECODE and is dropped.
        @(negedge sysclk);
        cmd = WR; addr = 8'd3; payload = 8'd0; frame_valid = 1'b1;
        @(negedge sysclk);
        payload = 8'd99;
        @(negedge sysclk);
        frame_valid = 1'b0;
        repeat (4) @(negedge sysclk);
        err_exp++;
        chk("err_busy_drop", err_seen, err_exp);

`ifndef LED_ERR_STATUS_EN
        send(RD, 8'hFF, 8'd0);
        err_exp++;
        chk("err_addr_ff", err_seen, err_exp);
        chk("addr_ff_no_tx", tx_enb, 0);
`endif

        read_led(8'd0, 8'd100, 1'b0);
        read_led(8'd1, 8'd50, 1'b0);
        read_led(8'd2, 8'd30, 1'b0);
        read_led(8'd3, 8'd0, 1'b0);

        // Duty change mid-period takes effect only from the next period.
        send(WR, 8'd3, 8'd80);
        repeat (2 * PERIOD) @(negedge sysclk);
        n = 0;
        while (!(led[3] && !tx_enb_d && n > 0 && n < 600) && n < 600) begin
            @(negedge sysclk);
            n++;
            if (led[3]) break;
        end
        // align to a rising edge of led[3]
        n = 0;
        while (led[3] && n < 600) begin @(negedge sysclk); n++; end
        n = 0;
        while (!led[3] && n < 600) begin @(negedge sysclk); n++; end
        chk("rise_found", led[3], 1);
        fork
            begin
                repeat (20) @(negedge sysclk);
                send(WR, 8'd3, 8'd20);
            end
            run_len(3, 1'b1, n_hi);
        join
        run_len(3, 1'b0, n_lo);
        run_len(3, 1'b1, n_hi2);
        chk("period_old_duty", n_hi, 80 * DIV);
        chk("period_gap", n_lo, 20 * DIV);
        chk("period_new_duty", n_hi2, 20 * DIV);

        // Reset while the readback is being held.
        cs = 1'b0;
        exp_q.push_back({RD, 8'd0, 8'd100});
        pulse_frame(RD, 8'd0, 8'd0);
        wait_tx();
        @(negedge sysclk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_enb", tx_enb, 0);
        chk("midrst_tx_frame", tx_frame, 0);
        chk("midrst_led", led, 0);
        @(negedge sysclk);
        rst_n = 1'b1;
        cs = 1'b1;
        repeat (2) @(negedge sysclk);
        read_led(8'd0, 8'd0, 1'b0);

`ifdef LED_ERR_STATUS_EN
        send(WR, 8'd9, 8'd0);
        send(8'h77, 8'd0, 8'd0);
        send(RD, 8'd5, 8'd0);
        err_exp += 3;
        chk("err_three", err_seen, err_exp);
        read_led(8'hFF, 8'd3, 1'b0);
        send(WR, 8'hFF, 8'd0);
        read_led(8'hFF, 8'd0, 1'b0);
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
